// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one shared truth-table lookup is stepped over every
// neuron, with runtime-writable truth tables and input-bit connectivity per neuron.
module lut_layer_sequencer #(
  parameter int IN_BITS = 64,
  parameter int NEURONS = 16,
  parameter int FANIN   = 6,
  parameter int IDX_W   = 6,
  parameter int NID_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_tt_we,
  input  logic               cfg_sel_we,
  input  logic [NID_W-1:0]   cfg_neuron,
  input  logic [FANIN-1:0]   cfg_addr,
  input  logic               cfg_tt_bit,
  input  logic [IDX_W-1:0]   cfg_sel_idx,
  output logic               cfg_reject,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_BITS-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [NEURONS-1:0] m_data,
  output logic               busy
);
  localparam int DEPTH  = 2**FANIN;
  localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_OUT} state_t;

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   tt  [NEURONS];
  logic [IDX_W-1:0]   sel [NEURONS][FANIN];
  logic [IN_BITS-1:0] in_reg;
  logic [NEURONS-1:0] out_reg;
  logic [NID_W-1:0]   cnt;
  logic [FANIN-1:0]   addr;
  logic               accept, tt_ok, sel_ok;

  // Out-of-range select indices fall back to bit 0 so no X can reach the lookup.
  function automatic logic pick_bit(input logic [IN_BITS-1:0] v, input logic [IDX_W-1:0] i);
    pick_bit = (int'(i) < IN_BITS) ? v[i] : v[0];
  endfunction

  assign accept = s_valid && s_ready;
  assign tt_ok  = cfg_tt_we && (state == S_IDLE);
  assign sel_ok = cfg_sel_we && (state == S_IDLE) && (int'(cfg_addr) < FANIN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (s_valid) state_nxt = S_EVAL;
      S_EVAL: if (cnt == NID_W'(NEURONS-1)) state_nxt = S_OUT;
      S_OUT:  if (m_ready) state_nxt = s_valid ? S_EVAL : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == S_IDLE) || ((state == S_OUT) && m_ready);
    m_valid = (state == S_OUT);
    busy    = (state == S_EVAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_reject <= 1'b0;
      cnt        <= '0;
    end else begin
      cfg_reject <= (cfg_tt_we && !tt_ok) || (cfg_sel_we && !sel_ok);
      if (accept)                cnt <= '0;
      else if (state == S_EVAL)  cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NEURONS; n++) begin
        tt[n] <= '0;
        for (int j = 0; j < FANIN; j++) sel[n][j] <= IDX_W'(j);
      end
    end else begin
      if (tt_ok)  tt[cfg_neuron][cfg_addr] <= cfg_tt_bit;
      if (sel_ok) sel[cfg_neuron][cfg_addr[SLOT_W-1:0]] <= cfg_sel_idx;
    end
  end

  // Stage: capture the accepted activation vector
  always_ff @(posedge clk) begin
    if (accept) in_reg <= s_data;
  end

  always_comb begin
    addr = '0;
    for (int j = 0; j < FANIN; j++) addr[j] = pick_bit(in_reg, sel[cnt][j]);
  end

  // Stage: one neuron lookup per cycle into the result vector
  always_ff @(posedge clk) begin
    if (rst)                   out_reg <= '0;
    else if (state == S_EVAL)  out_reg[cnt] <= tt[cnt][addr];
  end

  assign m_data = out_reg;
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: defaults, connectivity, backpressure,
// back-to-back handshakes, config rejection and mid-evaluation reset.
module tb_lut_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_tt_we, cfg_sel_we, cfg_tt_bit, cfg_reject;
  logic [3:0]  cfg_neuron;
  logic [5:0]  cfg_addr, cfg_sel_idx;
  logic        s_valid, s_ready, m_valid, m_ready, busy;
  logic [63:0] s_data;
  logic [15:0] m_data;
  int checks = 0;
  int failures = 0;

  lut_layer_sequencer dut (
    .clk(clk), .rst(rst), .cfg_tt_we(cfg_tt_we), .cfg_sel_we(cfg_sel_we),
    .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_tt_bit(cfg_tt_bit),
    .cfg_sel_idx(cfg_sel_idx), .cfg_reject(cfg_reject), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tt(input logic [3:0] n, input logic [5:0] a, input logic b);
    cfg_tt_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_tt_bit = b;
    step();
    cfg_tt_we = 1'b0;
  endtask

  task automatic write_sel(input logic [3:0] n, input logic [5:0] slot, input logic [5:0] idx);
    cfg_sel_we = 1'b1; cfg_neuron = n; cfg_addr = slot; cfg_sel_idx = idx;
    step();
    cfg_sel_we = 1'b0;
  endtask

  task automatic start_vec(input logic [63:0] d);
    s_valid = 1'b1; s_data = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!m_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input logic [63:0] d, input logic [15:0] exp);
    int lat;
    start_vec(d);
    wait_out(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges, expected 16", name, lat);
    end
    checks++;
    if (m_data !== exp) begin
      failures++;
      $display("FAIL %s_data: got %h, expected %h", name, m_data, exp);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: m_valid=%b, expected 0", name, m_valid);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_valid, cfg_reject, busy, s_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ctrl: {m_valid,cfg_reject,busy,s_ready}=%b, expected 0001",
               {m_valid, cfg_reject, busy, s_ready});
    end
    checks++;
    if (m_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mdata: got %h, expected 0000", m_data);
    end
  endtask

  task automatic test_default_tt();
    write_tt(4'd0, 6'h24, 1'b1);
    checks++;
    if (cfg_reject !== 1'b0) begin
      failures++;
      $display("FAIL idle_write_reject: got %b, expected 0", cfg_reject);
    end
    start_vec(64'h24);
    step();
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL eval_flags: busy=%b s_ready=%b, expected 1 0", busy, s_ready);
    end
    m_ready = 1'b1;
    while (!m_valid) step();
    checks++;
    if (m_data !== 16'h0001) begin
      failures++;
      $display("FAIL default_data: got %h, expected 0001", m_data);
    end
    step();
    m_ready = 1'b0;
    run_vec("default_zero", 64'h0, 16'h0000);
    run_vec("default_hit", 64'h24, 16'h0001);
  endtask

  task automatic test_sel();
    for (int j = 0; j < 6; j++) write_sel(4'd3, 6'(j), 6'(63 - j));
    write_tt(4'd3, 6'h3F, 1'b1);
    run_vec("sel_hit", 64'hFC00_0000_0000_0000, 16'h0008);
    run_vec("sel_miss", 64'h7C00_0000_0000_0000, 16'h0000);
    write_sel(4'd3, 6'd6, 6'd0);
    checks++;
    if (cfg_reject !== 1'b1) begin
      failures++;
      $display("FAIL sel_slot_reject: got %b, expected 1", cfg_reject);
    end
    step();
    checks++;
    if (cfg_reject !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse_width: got %b, expected 0", cfg_reject);
    end
    run_vec("sel_after_reject", 64'hFC00_0000_0000_0024, 16'h0009);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    start_vec(64'h24);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      if (m_valid !== 1'b1 || m_data !== 16'h0001 || s_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure_hold: %0d bad cycles, expected 0", bad);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: m_valid=%b s_ready=%b, expected 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra = 0;
    start_vec(64'h24);
    wait_out(lat);
    s_valid = 1'b1; s_data = 64'hFC00_0000_0000_0000; m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_s_ready: got %b, expected 1", s_ready);
    end
    step();
    s_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: m_valid=%b busy=%b, expected 0 1", m_valid, busy);
    end
    wait_out(lat);
    checks++;
    if (lat !== 16 || m_data !== 16'h0008) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d data=%h, expected 16 0008", lat, m_data);
    end
    m_ready = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      if (m_valid !== 1'b0 || busy !== 1'b0) extra++;
      step();
    end
    m_ready = 1'b0;
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL b2b_no_dup: %0d spurious cycles, expected 0", extra);
    end
  endtask

  task automatic test_cfg_reject_eval();
    int lat;
    start_vec(64'h24);
    step(); step();
    write_tt(4'd0, 6'h24, 1'b0);
    checks++;
    if (cfg_reject !== 1'b1) begin
      failures++;
      $display("FAIL eval_tt_reject: got %b, expected 1", cfg_reject);
    end
    wait_out(lat);
    checks++;
    if (m_data !== 16'h0001) begin
      failures++;
      $display("FAIL eval_reject_current: got %h, expected 0001", m_data);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    run_vec("eval_reject_next", 64'h24, 16'h0001);
  endtask

  task automatic test_rst_mid();
    start_vec(64'h24);
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_ctrl: m_valid=%b s_ready=%b busy=%b, expected 0 1 0",
               m_valid, s_ready, busy);
    end
    rst = 1'b0;
    run_vec("mid_rst_tt0", 64'h24, 16'h0000);
    run_vec("mid_rst_tt3", 64'hFC00_0000_0000_0000, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; cfg_tt_we = 1'b0; cfg_sel_we = 1'b0; cfg_neuron = '0; cfg_addr = '0;
    cfg_tt_bit = 1'b0; cfg_sel_idx = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_default_tt();
    test_sel();
    test_backpressure();
    test_back_to_back();
    test_cfg_reject_eval();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
